// File: rtl/subleq_loader.sv
// rtl/subleq_loader.sv - boot-time image loader and memory write-port arbiter for the subleq core
//
// Purpose: holds the core in reset, then writes a valid/ready byte stream into memory
// starting at address 0. Once the image ends it releases the core and hands the memory
// write port to the core as a zero-latency passthrough.
// Optional feature macro: SUBLEQ_LOADER_CHECKSUM_EN. When it is defined, the image must
// sum to 0x00 mod 256, otherwise the loader parks in ERROR.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_valid/i_data/i_last  image byte stream in; o_ready = loader accepts a byte
//   i_cpu_waddr/wdata/we core write port (used only in RUN)
//   o_waddr/o_wdata/o_we memory write port
//   o_cpu_rstn           core reset (active-low)
//   o_done               image loaded and core running
//   o_error              checksum failure (0 when the checksum is not built)
//   o_count              bytes written so far
module subleq_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_cpu_waddr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_cpu_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_we,
  output logic              o_cpu_rstn,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_count
);

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN, S_ERROR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ld_we_q, ld_we_d;
  logic [ADDR_W-1:0] ld_waddr_q, ld_waddr_d;
  logic [DATA_W-1:0] ld_wdata_q, ld_wdata_d;
  logic              ready_q, ready_d;
  logic              cpu_rstn_q, cpu_rstn_d;
  logic              done_q, done_d;
  logic              xfer;
  logic              img_end;

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, sum_next;
  logic       error_q, error_d;
  // The sum includes the byte being transferred, so the end-of-image decision
  // can be made on the same edge as the final transfer.
  assign sum_next = sum_q + 8'(i_data);
`endif

  assign xfer    = i_valid & ready_q;
  // The byte landing on the top address ends the image, so the pointer never wraps.
  assign img_end = xfer & (i_last | (addr_q == '1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    ld_we_d    = 1'b0;
    ld_waddr_d = ld_waddr_q;
    ld_wdata_d = ld_wdata_q;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    if (xfer) begin
      ld_we_d    = 1'b1;
      ld_waddr_d = addr_q;
      ld_wdata_d = i_data;
      addr_d     = addr_q + 1'b1;
      count_d    = count_q + 1'b1;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      sum_d      = sum_next;
`endif
    end
    case (state_q)
      S_LOAD: begin
        if (img_end) begin
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
          state_d = (sum_next == 8'h00) ? S_RELEASE : S_ERROR;
`else
          state_d = S_RELEASE;
`endif
        end
      end
      S_RELEASE: state_d = S_RUN;
      default:   state_d = state_q;
    endcase
    // Status outputs are registered from the next state so they line up with it.
    ready_d    = (state_d == S_LOAD);
    cpu_rstn_d = (state_d == S_RUN);
    done_d     = (state_d == S_RUN);
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    error_d    = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_LOAD;
      addr_q     <= '0;
      count_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_waddr_q <= '0;
      ld_wdata_q <= '0;
      ready_q    <= 1'b1;
      cpu_rstn_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      sum_q      <= 8'h00;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      ld_we_q    <= ld_we_d;
      ld_waddr_q <= ld_waddr_d;
      ld_wdata_q <= ld_wdata_d;
      ready_q    <= ready_d;
      cpu_rstn_q <= cpu_rstn_d;
      done_q     <= done_d;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      error_q    <= error_d;
`endif
    end
  end

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  // The core owns the write port only in RUN; otherwise only the loader can write.
  assign o_we       = (state_q == S_RUN) ? i_cpu_we    : ld_we_q;
  assign o_waddr    = (state_q == S_RUN) ? i_cpu_waddr : ld_waddr_q;
  assign o_wdata    = (state_q == S_RUN) ? i_cpu_wdata : ld_wdata_q;
  assign o_ready    = ready_q;
  assign o_cpu_rstn = cpu_rstn_q;
  assign o_done     = done_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_subleq_loader.sv
// tb/tb_subleq_loader.sv - self-checking bench for subleq_loader
module tb_subleq_loader;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_last = 1'b0;
  logic          o_ready;
  logic [AW-1:0] i_cpu_waddr = '0;
  logic [DW-1:0] i_cpu_wdata = '0;
  logic          i_cpu_we = 1'b0;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic          o_we;
  logic          o_cpu_rstn;
  logic          o_done;
  logic          o_error;
  logic [AW:0]   o_count;

  subleq_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .o_ready(o_ready), .i_cpu_waddr(i_cpu_waddr), .i_cpu_wdata(i_cpu_wdata),
    .i_cpu_we(i_cpu_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_we(o_we),
    .o_cpu_rstn(o_cpu_rstn), .o_done(o_done), .o_error(o_error), .o_count(o_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the image is the list of accepted bytes; byte i must land at address i.
  logic [7:0] sent[$];
  int         wa[$];
  int         wd[$];
  longint     wt[$];

  // Loader-side memory writes (anything written while the core is not running).
  always @(negedge clk) begin
    if (o_we === 1'b1 && o_done !== 1'b1) begin
      wa.push_back(int'(o_waddr));
      wd.push_back(int'(o_wdata));
      wt.push_back(longint'($time));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic image_runs();
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    foreach (sent[i]) s = s + sent[i];
    return (s == 8'h00);
`else
    return 1'b1;
`endif
  endfunction

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_cpu_we = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    i_rst = 1'b0;
    sent.delete(); wa.delete(); wd.delete(); wt.delete();
  endtask

  // Offer one byte after 'gap' idle cycles; returns one step after the accepting edge.
  task automatic send(input logic [7:0] d, input logic last, input int gap);
    logic acc;
    acc = 1'b0;
    i_valid = 1'b0; i_last = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    i_valid = 1'b1; i_data = d; i_last = last;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk); acc = o_ready;
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_last = 1'b0;
    if (acc) sent.push_back(d);
    else check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_writes(input string tag, input logic b2b);
    check({tag, "_nwrites"}, wa.size(), sent.size());
    for (int i = 0; i < wa.size() && i < sent.size(); i++) begin
      check({tag, "_waddr"}, wa[i], i);
      check({tag, "_wdata"}, wd[i], sent[i]);
      if (b2b && i > 0) check({tag, "_b2b"}, 32'(wt[i] - wt[i-1]), 32'd10);
    end
  endtask

  // Called right after the final transfer: checks the RELEASE/ERROR cycle, then the cycle after.
  task automatic finish_image(input string tag, input logic b2b);
    logic runs;
    i_cpu_we = 1'b0;
    runs = image_runs();
    @(negedge clk);
    check({tag, "_t1_ready"}, o_ready, 1'b0);
    check({tag, "_t1_we"}, o_we, 1'b1);
    check({tag, "_t1_waddr"}, o_waddr, sent.size() - 1);
    check({tag, "_t1_wdata"}, o_wdata, sent[sent.size()-1]);
    check({tag, "_t1_rstn"}, o_cpu_rstn, 1'b0);
    check({tag, "_t1_error"}, o_error, !runs);
    @(negedge clk);
    check({tag, "_t2_rstn"}, o_cpu_rstn, runs);
    check({tag, "_t2_done"}, o_done, runs);
    check({tag, "_t2_error"}, o_error, !runs);
    check({tag, "_t2_we"}, o_we, 1'b0);
    check({tag, "_count"}, o_count, sent.size());
    check_writes(tag, b2b);
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] a, d;
    logic       w;

    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_ready", o_ready, 1'b1);
    check("rst_we", o_we, 1'b0);
    check("rst_waddr", o_waddr, 0);
    check("rst_wdata", o_wdata, 0);
    check("rst_rstn", o_cpu_rstn, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_error", o_error, 1'b0);
    check("rst_count", o_count, 0);

    // Basic load, with the core trying to write during LOAD (must be ignored)
    @(posedge clk); #1;
    i_cpu_we = 1'b1; i_cpu_waddr = 8'h40; i_cpu_wdata = 8'hAA;
    send(8'h03, 1'b0, 0);
    send(8'h04, 1'b0, 0);
    send(8'h05, 1'b1, 0);
    finish_image("basic", 1'b1);

    // Stream input outside LOAD is not consumed
    i_valid = 1'b1; i_data = 8'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_ready", o_ready, 1'b0);
    check("post_count", o_count, 3);
    i_valid = 1'b0;

    // Throttled stream of 10 random bytes
    do_reset();
    for (int i = 0; i < 10; i++)
      send(8'($urandom), (i == 9), int'($urandom_range(0, 3)));
    finish_image("throttle", 1'b0);

    // Full image of 256 bytes without i_last
    do_reset();
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      if (i == 255) d = 8'h00 - s;
`endif
      s = s + d;
      send(d, 1'b0, 0);
    end
    finish_image("full", 1'b1);
    i_valid = 1'b1; i_data = 8'h55;
    @(negedge clk);
    check("full_257_ready", o_ready, 1'b0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    check("full_257_count", o_count, 256);

    // Passthrough in RUN: zero-latency copy of the core write port
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      a = (k == 0) ? 8'h40 : 8'($urandom);
      d = (k == 0) ? 8'hAA : 8'($urandom);
      w = (k != 2);
      i_cpu_waddr = a; i_cpu_wdata = d; i_cpu_we = w;
      #1;
      check("pass_we", o_we, w);
      check("pass_waddr", o_waddr, a);
      check("pass_wdata", o_wdata, d);
    end
    i_cpu_we = 1'b0;

    // Reset mid-load, then a fresh image starts at address 0
    do_reset();
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 0);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("midrst_count", o_count, 0);
    check("midrst_rstn", o_cpu_rstn, 1'b0);
    check("midrst_ready", o_ready, 1'b1);
    check("midrst_we", o_we, 1'b0);
    sent.delete(); wa.delete(); wd.delete(); wt.delete();
    @(posedge clk); #1;
    send(8'h21, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    send(8'hBD, 1'b1, 0);
    finish_image("reload", 1'b1);

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    // Checksum good: 0x10 + 0xF0 = 0x00
    do_reset();
    send(8'h10, 1'b0, 0);
    send(8'hF0, 1'b1, 0);
    finish_image("csum_ok", 1'b1);

    // Checksum bad: 0x10 + 0xEF = 0xFF, held in ERROR until reset
    do_reset();
    send(8'h10, 1'b0, 0);
    send(8'hEF, 1'b1, 0);
    finish_image("csum_bad", 1'b1);
    i_valid = 1'b1; i_cpu_we = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("err_hold_error", o_error, 1'b1);
    check("err_hold_rstn", o_cpu_rstn, 1'b0);
    check("err_hold_ready", o_ready, 1'b0);
    check("err_hold_we", o_we, 1'b0);
    check("err_hold_count", o_count, 2);
    do_reset();
    @(negedge clk);
    check("err_clear", o_error, 1'b0);
    check("err_clear_ready", o_ready, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subleq_loader.md
# subleq_loader

Boot-time program loader and write-port arbiter between the subleq core and its memory. After reset it holds the core in reset, accepts a byte stream over a valid/ready handshake and writes it to consecutive memory addresses from 0. When the image is complete it releases the core and passes the core's write port through to memory unchanged.

## Interface
Parameters:
- `ADDR_W`, default 8: memory address width; image capacity is 2^ADDR_W bytes.
- `DATA_W`, default 8: memory data width.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  stream byte valid.
- `i_data`  in  DATA_W  stream byte.
- `i_last`  in  1  qualifies the final byte of the image.
- `o_ready`  out  1  loader accepts a byte this cycle.
- `i_cpu_waddr`  in  ADDR_W  core write address.
- `i_cpu_wdata`  in  DATA_W  core write data.
- `i_cpu_we`  in  1  core write enable.
- `o_waddr`  out  ADDR_W  memory write address.
- `o_wdata`  out  DATA_W  memory write data.
- `o_we`  out  1  memory write enable.
- `o_cpu_rstn`  out  1  core reset, active-low; 0 holds the core.
- `o_done`  out  1  image loaded and core running.
- `o_error`  out  1  checksum failure (see Configuration).
- `o_count`  out  ADDR_W+1  bytes written so far.

## Operation
- States: LOAD, RELEASE, RUN, ERROR. Reset enters LOAD.
- A transfer happens when `i_valid & o_ready`. `o_ready` = 1 only in LOAD.
- On each transfer:
  - Register the write address, data and `o_we`=1 for exactly one cycle.
  - Increment the address pointer and `o_count`.
- End of image is the first transfer with `i_last`=1, or the transfer written to address 2^ADDR_W−1, whichever comes first.
  - Address wrap is impossible; a full image of 2^ADDR_W bytes ends the load automatically.
  - `i_last` on that same byte is redundant and harmless.
- End of image moves LOAD to RELEASE. RELEASE lasts one cycle, then RUN.
- RUN:
  - `o_cpu_rstn`=1 and `o_done`=1.
  - `o_waddr`/`o_wdata`/`o_we` are combinational copies of `i_cpu_*`.
- LOAD/RELEASE/ERROR: core write port inputs are ignored; `o_we` is driven only by the loader.
- `i_valid` outside LOAD is ignored, and no byte is consumed.
- `i_rst` at any time, including mid-load or in RUN, forces the reset values on the next edge. A partial image is simply overwritten by the next load.
- Reset values:
  - state LOAD, `o_ready`=1 (after reset), `o_we`=0, `o_waddr`=0, `o_wdata`=0.
  - `o_cpu_rstn`=0, `o_done`=0, `o_error`=0, `o_count`=0.

## Timing
- A transfer at edge t produces `o_we`=1 with the matching address/data during cycle t+1.
- Back-to-back transfers give back-to-back writes, one byte per cycle. No bubbles are required.
- If the final transfer is at edge t:
  - its write is in cycle t+1 (RELEASE);
  - `o_ready` falls in cycle t+1;
  - `o_cpu_rstn` and `o_done` rise in cycle t+2 (RUN).
- The core therefore never leaves reset while a loader write is outstanding.
- RUN passthrough has zero latency.

## Configuration
- `SUBLEQ_LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum (mod 256, low 8 bits of each byte) covers every transferred byte, including the final one.
  - At end of image, a sum of 0x00 follows the normal path (RELEASE, then RUN).
  - Any other sum goes to ERROR in cycle t+1. The final byte is still written.
  - In ERROR: `o_error`=1, `o_ready`=0, `o_cpu_rstn`=0, held until `i_rst`.
- Not defined: no sum register; `o_error` is tied to 0; the ERROR state is unreachable.

## Test plan
- **Basic load:** reset, stream 0x03,0x04,0x05 with `i_last` on 0x05 →
  - writes (0,0x03),(1,0x04),(2,0x05) on consecutive cycles;
  - `o_count`=3;
  - `o_cpu_rstn`=1 two cycles after the last transfer.
- **Throttled stream:** toggle `i_valid` randomly across 10 bytes → exactly 10 writes at addresses 0..9 in order, none duplicated or skipped.
- **Full image:** 256 bytes, no `i_last` →
  - last write at address 0xFF;
  - `o_count`=256, RUN entered;
  - a 257th `i_valid` is not accepted (`o_ready`=0).
- **Passthrough and isolation:**
  - In RUN, drive `i_cpu_we`=1, addr 0x40, data 0xAA → same cycle `o_we`=1, `o_waddr`=0x40, `o_wdata`=0xAA.
  - During LOAD, the same core stimulus produces no memory write.
- **Reset mid-load:** assert `i_rst` after 5 bytes →
  - next cycle `o_count`=0, `o_cpu_rstn`=0;
  - a new stream writes from address 0.
- **Checksum (macro on):**
  - Stream 0x10,0xF0 with `i_last` → sum 0x00, RUN.
  - Stream 0x10,0xEF → `o_error`=1, `o_cpu_rstn` stays 0 until reset.
